mem_access_stage: RTL

Memory-stage access unit and MEM/WB pipeline register. Consumes the MEM_* control and data outputs of the EX/MEM register, issues word loads/stores to data memory over a valid/ready handshake, and stalls the upstream pipeline until the access completes. Forwards the write-back value into store data on an rs2 hazard, then registers the result for the WB stage.

---
 rtl/mem_access_stage_pkg.sv | 13 +
 rtl/mem_wb_reg.sv | 42 ++++
 rtl/mem_access_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared constants and FSM state encoding for the memory access stage
package mem_access_stage_pkg;

    localparam logic [31:0] ZERO_VECTOR_32 = 32'h0000_0000;
    localparam logic [4:0]  ZERO_VECTOR_5  = 5'd0;

    typedef enum logic [1:0] {
        MEMST_IDLE = 2'b00,
        MEMST_REQ  = 2'b01,
        MEMST_DONE = 2'b10
    } memst_e;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load-enable and bubble insertion
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        bubble,
    input  logic        wbsrc,
    input  logic        regwrite,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [4:0]  rd,
    output logic        wb_wbsrc,
    output logic        wb_regwrite,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd
);

    // A bubble clears only the control fields; data fields keep their last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_wbsrc      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_alu_result <= ZERO_VECTOR_32;
            wb_mem_data   <= ZERO_VECTOR_32;
            wb_rd         <= ZERO_VECTOR_5;
        end else if (bubble) begin
            wb_wbsrc      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= ZERO_VECTOR_5;
        end else if (load_en) begin
            wb_wbsrc      <= wbsrc;
            wb_regwrite   <= regwrite;
            wb_alu_result <= alu_result;
            wb_mem_data   <= mem_data;
            wb_rd         <= rd;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory access FSM, store forwarding and MEM/WB register (option: MEM_MISALIGN_CHECK_EN)
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_WBSrc,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic [31:0] MEM_ALU_Result,
    input  logic [31:0] MEM_Read_data_2,
    input  logic [4:0]  MEM_rd,
    input  logic [4:0]  MEM_rs2,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        WB_WBSrc,
    output logic        WB_RegWrite,
    output logic [31:0] WB_ALU_Result,
    output logic [31:0] WB_Mem_data,
    output logic [4:0]  WB_rd
);

    memst_e      state;
    logic        access;
    logic        misaligned;
    logic        fwd_hit;
    logic [31:0] store_data;
    logic [31:0] load_buf;
    logic [31:0] wb_mem_data_next;
    logic        wb_load;
    logic        wb_bubble;

    assign access = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned   = access && (MEM_ALU_Result[1:0] != 2'b00);
    assign mem_misalign = reset && (state == MEMST_IDLE) && misaligned;
`else
    assign misaligned   = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    // The instruction ahead of us sits in MEM/WB; forward its write-back value into store data.
    assign fwd_hit    = WB_RegWrite && (WB_rd == MEM_rs2) && (MEM_rs2 != ZERO_VECTOR_5);
    assign store_data = fwd_hit ? (WB_WBSrc ? WB_Mem_data : WB_ALU_Result) : MEM_Read_data_2;

    assign mem_stall = ((state == MEMST_IDLE) && access && !misaligned) || (state == MEMST_REQ);

    assign wb_bubble        = mem_stall || ((state == MEMST_IDLE) && misaligned);
    assign wb_load          = (state == MEMST_DONE) || ((state == MEMST_IDLE) && !access);
    assign wb_mem_data_next = ((state == MEMST_DONE) && !dmem_we) ? load_buf : ZERO_VECTOR_32;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MEMST_IDLE;
            dmem_valid <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= ZERO_VECTOR_32;
            dmem_wdata <= ZERO_VECTOR_32;
            load_buf   <= ZERO_VECTOR_32;
        end else begin
            case (state)
                MEMST_IDLE: begin
                    if (access && !misaligned) begin
                        dmem_valid <= 1'b1;
                        dmem_we    <= MEM_MemWrite;
                        dmem_addr  <= {MEM_ALU_Result[31:2], 2'b00};
                        dmem_wdata <= store_data;
                        state      <= MEMST_REQ;
                    end
                end
                MEMST_REQ: begin
                    if (dmem_ready) begin
                        load_buf   <= dmem_rdata;
                        dmem_valid <= 1'b0;
                        state      <= MEMST_DONE;
                    end
                end
                MEMST_DONE: begin
                    state <= MEMST_IDLE;
                end
                default: begin
                    state      <= MEMST_IDLE;
                    dmem_valid <= 1'b0;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk),
        .reset         (reset),
        .load_en       (wb_load),
        .bubble        (wb_bubble),
        .wbsrc         (MEM_WBSrc),
        .regwrite      (MEM_RegWrite),
        .alu_result    (MEM_ALU_Result),
        .mem_data      (wb_mem_data_next),
        .rd            (MEM_rd),
        .wb_wbsrc      (WB_WBSrc),
        .wb_regwrite   (WB_RegWrite),
        .wb_alu_result (WB_ALU_Result),
        .wb_mem_data   (WB_Mem_data),
        .wb_rd         (WB_rd)
    );

endmodule
